context_scheduler: RTL
======================

Name: context_scheduler

Overview:
- Sequences the front end. Holds up to N_CTX hardware contexts, each with a PC and a state.
- Each cycle it picks one runnable context round-robin and issues it (order, pc, context) to fetch/decode.
- Retires decode's next-PC result back into that context's PC.
- Forks a second context on conditional branches.
- Parks a context on unresolved control flow until exec resolves it or kills it.

Parameters:
- N_CTX, 4, number of contexts (power of two, 2..16).
- CTX_W, 2, context id width (= `LEN_CONTEXT, log2 N_CTX).
- WORD_W, 32, PC width (= `LEN_WORD).
- RESET_PC, 32'h0, start PC of context 0.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  inst_window full; no issue while high.
- order  out  1  issue strobe to fetch/decode.
- issue_pc  out  WORD_W  PC of the issued context.
- issue_ctx  out  CTX_W  id of the issued context.
- next_pc_ready  in  1  decode: next PC known (same cycle as order).
- branch  in  1  decode: conditional branch (same cycle as order).
- next_pc  in  WORD_W  decode: taken/sequential target.
- next_pc_f  in  WORD_W  decode: fall-through PC.
- resolve_valid  in  1  exec: parked context's PC resolved.
- resolve_ctx  in  CTX_W  context being resolved.
- resolve_pc  in  WORD_W  resolved PC.
- kill_valid  in  1  exec: free a context (mispredicted path).
- kill_ctx  in  CTX_W  context to free.
- fork_valid  out  1  pulse: a new context was allocated.
- fork_ctx  out  CTX_W  the new context's id.
- fork_parent  out  CTX_W  id of the branching context.
- all_idle  out  1  no context in RUN or WAIT.

Behaviour:
- Per-context state: FREE, RUN, WAIT, plus pc[WORD_W]. All registered.
- Reset (rstn=0, asynchronous):
  - ctx0 = RUN, pc = RESET_PC; all other contexts FREE, pc = 0.
  - Round-robin pointer = N_CTX-1, so ctx0 is first.
  - fork_valid = 0, fork_ctx = 0, fork_parent = 0.
  - order is 0 while rstn is low.
- Issue selection (combinational from registered state):
  - Candidates are RUN contexts only.
  - Search starts at rr_ptr+1 and wraps modulo N_CTX.
  - order = |candidates & ~stall; issue_ctx/issue_pc = the selected context.
  - When order=0, issue_ctx/issue_pc hold the last selected value; they are don't-care for checking.
  - rr_ptr updates to issue_ctx only on cycles with order=1.
- Issue result (decode is combinational; results sampled at the clock edge ending the order cycle):
  - branch=1, some context FREE in registered state:
    - Issued pc <= next_pc.
    - Lowest-index FREE context <= RUN with pc = next_pc_f.
    - Next cycle: fork_valid=1 for one cycle, fork_ctx = allocated id, fork_parent = issued id.
  - branch=1, no FREE context: no update. The context re-issues the same PC later (decode output is discarded downstream by the absence of fork_valid).
  - branch=0, next_pc_ready=1: issued pc <= next_pc.
  - Both low (jalr / undecided): issued context <= WAIT, pc unchanged.
- Resolve: if resolve_ctx is in WAIT, it becomes RUN with pc <= resolve_pc. Otherwise the resolve is ignored.
- Kill: kill_ctx <= FREE regardless of state.
  - Kill overrides a same-cycle resolve or issue update on that context.
  - A context freed this cycle is not allocatable until the next cycle.
  - Killing the last live context makes all_idle=1. The scheduler then stays idle until reset.
- Same-cycle events on different contexts are all applied.
- fork_valid deasserts the cycle after it pulses unless another fork occurs.
- PC arithmetic is done in decode; this block never adds. Wrap-around is native WORD_W.
- all_idle = no context in RUN or WAIT (registered state, combinational output).

Test Plan:
- Reset release, decode always next_pc_ready=1 with next_pc = pc+4, stall=0 -> order every cycle, issue_ctx=0, issue_pc 0,4,8,12...
- Branch at pc 0x10, next_pc=0x40, next_pc_f=0x14 -> ctx0 pc=0x40, ctx1 RUN pc=0x14, fork_valid=1/fork_ctx=1/fork_parent=0 one cycle later; issue then alternates ctx1, ctx0.
- Four live contexts, another branch, branch at 0x80 -> no fork_valid, same context re-issues 0x80 on its next turn; after kill_ctx=2 it forks into ctx2.
- branch=0, next_pc_ready=0 on ctx0 at 0x20 -> ctx0 WAIT, not issued (order=0 if sole context, all_idle=0); resolve_ctx=0, pc=0x100 -> next issue pc=0x100.
- Same-cycle resolve_ctx=1 and kill_ctx=1 -> ctx1 FREE. Resolve to a RUN context -> ignored, pc unchanged.
- stall=1 for 3 cycles mid-stream -> order=0, PCs and rr_ptr frozen; rstn low mid-run -> ctx0 RUN at RESET_PC, others FREE, immediately.

Source files
------------

// File: rtl/context_scheduler.sv
// -----------------------------------------------------------------------------
// context_scheduler
//
// Front-end sequencer for up to N_CTX hardware contexts. Each context holds a
// PC and a state (FREE / RUN / WAIT). Every cycle one RUN context is picked
// round-robin and issued to fetch/decode. Decode's same-cycle answer updates
// the issued context's PC, forks a new context on a conditional branch, or
// parks the context in WAIT until exec resolves it. Exec can also kill any
// context, returning it to FREE.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   stall                fetch window full: suppress issue
//   order                issue strobe to fetch/decode
//   issue_pc, issue_ctx  PC and id of the issued context
//   next_pc_ready        decode: next PC known (same cycle as order)
//   branch               decode: conditional branch (same cycle as order)
//   next_pc, next_pc_f   decode: taken/sequential target, fall-through PC
//   resolve_valid/ctx/pc exec: resolved PC for a parked context
//   kill_valid/ctx       exec: free a context
//   fork_valid/ctx/parent pulse after a fork: new id and branching id
//   all_idle             no context is in RUN or WAIT
// -----------------------------------------------------------------------------
module context_scheduler #(
    parameter int                N_CTX    = 4,
    parameter int                CTX_W    = 2,
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    output logic              order,
    output logic [WORD_W-1:0] issue_pc,
    output logic [CTX_W-1:0]  issue_ctx,
    input  logic              next_pc_ready,
    input  logic              branch,
    input  logic [WORD_W-1:0] next_pc,
    input  logic [WORD_W-1:0] next_pc_f,
    input  logic              resolve_valid,
    input  logic [CTX_W-1:0]  resolve_ctx,
    input  logic [WORD_W-1:0] resolve_pc,
    input  logic              kill_valid,
    input  logic [CTX_W-1:0]  kill_ctx,
    output logic              fork_valid,
    output logic [CTX_W-1:0]  fork_ctx,
    output logic [CTX_W-1:0]  fork_parent,
    output logic              all_idle
);

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]        state_reg [N_CTX];
    logic [1:0]        state_next[N_CTX];
    logic [WORD_W-1:0] pc_reg    [N_CTX];
    logic [WORD_W-1:0] pc_next   [N_CTX];
    logic [CTX_W-1:0]  rr_ptr_reg,      rr_ptr_next;
    logic              fork_valid_reg,  fork_valid_next;
    logic [CTX_W-1:0]  fork_ctx_reg,    fork_ctx_next;
    logic [CTX_W-1:0]  fork_parent_reg, fork_parent_next;

    logic [N_CTX-1:0]  run_vec, wait_vec, free_vec;
    logic              sel_found, free_found, issue_go;
    logic [CTX_W-1:0]  sel_ctx, free_ctx, cand;

    for (genvar gi = 0; gi < N_CTX; gi++) begin : g_ctx_flags
        assign run_vec[gi]  = (state_reg[gi] == ST_RUN);
        assign wait_vec[gi] = (state_reg[gi] == ST_WAIT);
        assign free_vec[gi] = (state_reg[gi] == ST_FREE);
    end

    // Round-robin pick: scan offsets N_CTX down to 1 so the smallest offset
    // from rr_ptr (i.e. rr_ptr+1 first) is the last to win. Offset N_CTX
    // wraps to rr_ptr itself, which makes a sole runnable context re-issue.
    always_comb begin
        sel_found = 1'b0;
        sel_ctx   = rr_ptr_reg;
        cand      = rr_ptr_reg;
        for (int k = N_CTX; k >= 1; k--) begin
            cand = rr_ptr_reg + CTX_W'(k);
            if (run_vec[cand]) begin
                sel_found = 1'b1;
                sel_ctx   = cand;
            end
        end
    end

    // Lowest-index FREE context from registered state; a context killed this
    // cycle is still non-FREE here, so it cannot be reallocated until next cycle.
    always_comb begin
        free_found = 1'b0;
        free_ctx   = '0;
        for (int i = N_CTX - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_found = 1'b1;
                free_ctx   = CTX_W'(i);
            end
        end
    end

    // rstn gates the strobe so nothing issues while reset is held.
    assign issue_go = sel_found & ~stall & rstn;

    // Next-state: issue result, then resolve, then kill (kill has the last word).
    always_comb begin
        for (int i = 0; i < N_CTX; i++) begin
            state_next[i] = state_reg[i];
            pc_next[i]    = pc_reg[i];
        end
        rr_ptr_next      = rr_ptr_reg;
        fork_valid_next  = 1'b0;
        fork_ctx_next    = fork_ctx_reg;
        fork_parent_next = fork_parent_reg;

        if (issue_go) begin
            rr_ptr_next = sel_ctx;
            if (branch) begin
                // Without a free slot the decode result is dropped and the
                // same PC is re-issued on the context's next turn.
                if (free_found) begin
                    pc_next[sel_ctx]    = next_pc;
                    state_next[free_ctx] = ST_RUN;
                    pc_next[free_ctx]    = next_pc_f;
                    fork_valid_next      = 1'b1;
                    fork_ctx_next        = free_ctx;
                    fork_parent_next     = sel_ctx;
                end
            end else if (next_pc_ready) begin
                pc_next[sel_ctx] = next_pc;
            end else begin
                state_next[sel_ctx] = ST_WAIT;
            end
        end

        if (resolve_valid && (state_reg[resolve_ctx] == ST_WAIT)) begin
            state_next[resolve_ctx] = ST_RUN;
            pc_next[resolve_ctx]    = resolve_pc;
        end

        if (kill_valid) begin
            state_next[kill_ctx] = ST_FREE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CTX; i++) begin
                state_reg[i] <= (i == 0) ? ST_RUN : ST_FREE;
                pc_reg[i]    <= (i == 0) ? RESET_PC : '0;
            end
            rr_ptr_reg      <= CTX_W'(N_CTX - 1);
            fork_valid_reg  <= 1'b0;
            fork_ctx_reg    <= '0;
            fork_parent_reg <= '0;
        end else begin
            for (int i = 0; i < N_CTX; i++) begin
                state_reg[i] <= state_next[i];
                pc_reg[i]    <= pc_next[i];
            end
            rr_ptr_reg      <= rr_ptr_next;
            fork_valid_reg  <= fork_valid_next;
            fork_ctx_reg    <= fork_ctx_next;
            fork_parent_reg <= fork_parent_next;
        end
    end

    assign order       = issue_go;
    assign issue_ctx   = sel_ctx;
    assign issue_pc    = pc_reg[sel_ctx];
    assign fork_valid  = fork_valid_reg;
    assign fork_ctx    = fork_ctx_reg;
    assign fork_parent = fork_parent_reg;
    assign all_idle    = ~|(run_vec | wait_vec);

endmodule
